// File: rtl/cube_scan.sv
// Scan-out engine for the 8x8x8 LED cube: snapshots the cell array once per frame
// and shifts one 64-bit layer at a time into the column chain, then latches and lights it.
module cube_scan #(
  parameter int CLK_DIV = 4,
  parameter int DWELL   = 1000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [511:0] Cells,
  output logic         Sclk,
  output logic         Sdata,
  output logic         Latch,
  output logic [7:0]   Layer,
  output logic         Frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_BLANK, S_DWELL} state_t;

  state_t         state, state_next;
  logic [DW-1:0]  div_cnt;
  logic [WW-1:0]  dwell_cnt;
  logic [5:0]     bit_cnt;
  logic [2:0]     layer_idx;
  logic [511:0]   frame_buf;
  logic [63:0]    shreg;
  logic           sclk_q;
  logic [7:0]     layer_q;
  logic           done_q;
  logic           div_last;
  logic           shift_done;
  logic           dwell_last;

  assign div_last   = (div_cnt == DW'(CLK_DIV - 1));
  assign shift_done = (state == S_SHIFT) && div_last && sclk_q && (bit_cnt == 6'd63);
  assign dwell_last = (state == S_DWELL) && (dwell_cnt == WW'(DWELL - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  state_next = S_SHIFT;
      S_SHIFT: if (shift_done) state_next = S_BLANK;
      S_BLANK: state_next = S_DWELL;
      S_DWELL: if (dwell_last) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt   <= '0;
      dwell_cnt <= '0;
      bit_cnt   <= '0;
      layer_idx <= '0;
      frame_buf <= '0;
      shreg     <= '0;
      sclk_q    <= 1'b0;
      layer_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= dwell_last && (layer_idx == 3'd7);
      case (state)
        S_LOAD: begin
          // Layer 0 takes its bits straight from Cells while the snapshot is captured.
          if (layer_idx == 3'd0) begin
            frame_buf <= Cells;
            shreg     <= Cells[63:0];
          end else begin
            shreg <= frame_buf[{layer_idx, 6'd0} +: 64];
          end
          div_cnt <= '0;
          sclk_q  <= 1'b0;
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            if (sclk_q) begin
              shreg   <= {shreg[62:0], 1'b0};
              bit_cnt <= bit_cnt + 6'd1;
            end
            if (shift_done) layer_q <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_BLANK: begin
          dwell_cnt <= '0;
          layer_q   <= 8'b1 << layer_idx;
        end
        S_DWELL: begin
          dwell_cnt <= dwell_cnt + 1'b1;
          if (dwell_last) layer_idx <= layer_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign Sclk       = sclk_q;
  assign Sdata      = (state == S_SHIFT) && shreg[63];
  assign Latch      = (state == S_BLANK);
  assign Layer      = layer_q;
  assign Frame_done = done_q;

endmodule

// File: tb/tb_cube_scan.sv
// Directed bench for cube_scan: a fast instance (CLK_DIV=1, DWELL=4) for sequencing
// and data, and a default-timing instance (CLK_DIV=4, DWELL=1000) for the divider.
module tb_cube_scan;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         rst2_n = 1'b1;
  logic [511:0] cells = '0;
  logic [511:0] cells2 = {8{64'hF0F0_3C3C_AA55_0FF0}};
  logic         sclk, sdata, latch, frame_done;
  logic [7:0]   layer;
  logic         sclk2, sdata2, latch2, frame_done2;
  logic [7:0]   layer2;

  always #5 clk = ~clk;

  cube_scan #(.CLK_DIV(1), .DWELL(4)) dut (
    .Clk(clk), .Reset(rst_n), .Cells(cells), .Sclk(sclk), .Sdata(sdata),
    .Latch(latch), .Layer(layer), .Frame_done(frame_done)
  );

  cube_scan #(.CLK_DIV(4), .DWELL(1000)) dut2 (
    .Clk(clk), .Reset(rst2_n), .Cells(cells2), .Sclk(sclk2), .Sdata(sdata2),
    .Latch(latch2), .Layer(layer2), .Frame_done(frame_done2)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor state for the fast instance; img[f] is the image frame f should show.
  int           cyc, rises, latch_no, fd_no, first_rise, bmm_bad, oh_bad;
  logic [63:0]  acc;
  logic         sclk_prev;
  bit           pend, early;
  logic [511:0] img [2];

  task automatic mon_reset();
    cyc = 0; rises = 0; latch_no = 0; fd_no = 0; first_rise = -1;
    bmm_bad = 0; oh_bad = 0; acc = '0; sclk_prev = 1'b0; pend = 1'b0;
  endtask

  task automatic observe();
    logic [7:0] exp_layer;
    if (latch && layer != 8'h00) bmm_bad++;
    if ($countones(layer) > 1) oh_bad++;
    if (early && cyc >= 129 && cyc <= 133)
      check("layer_early", 64'(layer), (cyc == 129) ? 64'h00 : 64'h01);
    if (sclk && !sclk_prev) begin
      rises++;
      acc = {acc[62:0], sdata};
      if (first_rise < 0) first_rise = cyc;
    end
    if (pend) begin
      exp_layer = 8'h01 << ((latch_no - 1) % 8);
      check("layer_walk", 64'(layer), 64'(exp_layer));
      pend = 1'b0;
    end
    if (latch) begin
      if (latch_no == 0) check("first_latch", 64'(cyc), 64'd129);
      check("latch_rises", 64'(rises), 64'd64);
      if (latch_no < 16)
        check("col_data", acc, img[latch_no / 8][(latch_no % 8) * 64 +: 64]);
      rises = 0;
      latch_no++;
      pend = 1'b1;
    end
    if (frame_done) begin
      check("frame_done_cycle", 64'(cyc), 64'(1072 * (fd_no + 1)));
      fd_no++;
    end
    sclk_prev = sclk;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
      observe();
    end
  endtask

  task automatic start(input logic [511:0] c);
    rst_n = 1'b0;
    cells = c;
    repeat (10) begin
      @(posedge clk); #1;
      check("reset_idle", 64'({sclk, sdata, latch, layer, frame_done}), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_reset();
    #1 observe();
  endtask

  task automatic phase_end(input int nlatch, input int nfd);
    check("first_rise", 64'(first_rise), 64'd2);
    check("latch_count", 64'(latch_no), 64'(nlatch));
    check("frame_done_count", 64'(fd_no), 64'(nfd));
    check("break_before_make", 64'(bmm_bad), 64'd0);
    check("layer_onehot", 64'(oh_bad), 64'd0);
  endtask

  logic [511:0] pat;
  int c2, run2, rises_l2, first_rise2, latch_cnt2, bad_hi, bad_lo, hi_runs;
  logic prev2;

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;

    // Bit order and sequencing: only cell x0,y0,z0 alive.
    early = 1'b1;
    img[0] = 512'h1;
    img[1] = 512'h1;
    start(512'h1);
    watch(2150);
    phase_end(16, 2);
    early = 1'b0;

    // Snapshot coherence: Cells cleared mid layer 2 only shows in the next frame.
    img[0] = '1;
    img[1] = '0;
    start('1);
    watch(300);
    cells = '0;
    watch(1850);
    phase_end(16, 2);

    // Reset during layer 5 shift, then restart with a per-layer pattern.
    start('1);
    watch(700);
    check("pre_reset_sclk", 64'(sclk), 64'd1);
    check("pre_reset_layer", 64'(layer), 64'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", 64'({sclk, sdata, latch, layer}), 64'd0);
    for (int unsigned z = 0; z < 8; z++)
      pat[z * 64 +: 64] = 64'h8000_0000_0000_00A5 | (64'(z + 1) << 24);
    img[0] = pat;
    img[1] = pat;
    start(pat);
    watch(300);
    phase_end(2, 0);

    // Divider instance at default timing.
    @(negedge clk);
    rst2_n = 1'b1;
    c2 = 0; run2 = 1; rises_l2 = 0; first_rise2 = -1; latch_cnt2 = 0;
    bad_hi = 0; bad_lo = 0; hi_runs = 0;
    #1 prev2 = sclk2;
    repeat (2100) begin
      @(posedge clk); #1;
      c2++;
      if (sclk2 == prev2) begin
        run2++;
      end else begin
        if (prev2) begin
          hi_runs++;
          if (run2 != 4) bad_hi++;
        end else begin
          if (rises_l2 > 0 && run2 != 4) bad_lo++;
          if (first_rise2 < 0) first_rise2 = c2;
          rises_l2++;
        end
        run2 = 1;
      end
      prev2 = sclk2;
      if (latch2) begin
        check("div_latch_cycle", 64'(c2), 64'(513 + 1514 * latch_cnt2));
        check("div_latch_rises", 64'(rises_l2), 64'd64);
        latch_cnt2++;
        rises_l2 = 0;
      end
    end
    check("div_first_rise", 64'(first_rise2), 64'd5);
    check("div_latch_count", 64'(latch_cnt2), 64'd2);
    check("div_high_runs", 64'(hi_runs), 64'd128);
    check("div_high_len_bad", 64'(bad_hi), 64'd0);
    check("div_low_len_bad", 64'(bad_lo), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
